// File: rtl/lsu_pma_arb.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_pma_arb
//  Description : Shares the single LSU PMA/IO-region checker between the LSQ
//                store and load requesters. One lookup is granted per cycle.
//                Stores have priority, and a counter stops loads from starving.
//                The checker has one cycle of latency; its result comes back
//                as {tag, is_st, is_io} on a valid/ready response port.
//
//  Ports
//    clk, rstn            clock, asynchronous active-low reset
//    flush                pipeline flush (same cycle as the checker's flush)
//    st_req_*             store lookup request / accept (rdy == grant)
//    ld_req_*             load lookup request / accept (rdy == grant)
//    pma_st_*             to checker: store valid + paddr in the grant cycle
//    pma_ld_vld_o         to checker: load valid in the grant cycle
//    pma_ld_paddr_o,
//    pma_ld_dtlb_hit_o    to checker: load paddr / DTLB hit in the result cycle
//    pma_is_io_i          checker result, valid the cycle after a grant
//    rsp_*                response {tag, is_st, is_io} with valid/ready
//
//  Revision    : 1.0  initial release
// ============================================================================
module lsu_pma_arb #(
  parameter int PHYSICAL_ADDR_LEN = 56,
  parameter int TAG_W             = 4,
  parameter int LD_STARVE_MAX     = 4
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         flush,

  input  logic                         st_req_vld_i,
  input  logic [PHYSICAL_ADDR_LEN-1:0] st_req_paddr_i,
  input  logic [TAG_W-1:0]             st_req_tag_i,
  output logic                         st_req_rdy_o,

  input  logic                         ld_req_vld_i,
  input  logic [PHYSICAL_ADDR_LEN-1:0] ld_req_paddr_i,
  input  logic                         ld_req_dtlb_hit_i,
  input  logic [TAG_W-1:0]             ld_req_tag_i,
  output logic                         ld_req_rdy_o,

  output logic                         pma_st_vld_o,
  output logic [PHYSICAL_ADDR_LEN-1:0] pma_st_paddr_o,
  output logic                         pma_ld_vld_o,
  output logic [PHYSICAL_ADDR_LEN-1:0] pma_ld_paddr_o,
  output logic                         pma_ld_dtlb_hit_o,
  input  logic                         pma_is_io_i,

  output logic                         rsp_vld_o,
  input  logic                         rsp_rdy_i,
  output logic [TAG_W-1:0]             rsp_tag_o,
  output logic                         rsp_is_st_o,
  output logic                         rsp_is_io_o
);

  // Counter must be able to hold LD_STARVE_MAX itself.
  localparam int                c_CNT_W       = $clog2(LD_STARVE_MAX + 1);
  localparam logic [c_CNT_W-1:0] c_STARVE_MAX = c_CNT_W'(LD_STARVE_MAX);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,   // nothing in flight
    S_LOOKUP = 2'd1,   // checker result arrives this cycle
    S_HOLD   = 2'd2    // result buffered, waiting for rsp_rdy_i
  } state_t;

  state_t                       r_state;
  logic [c_CNT_W-1:0]           r_starve_cnt;
  logic [TAG_W-1:0]             r_tag;
  logic                         r_is_st;
  logic [PHYSICAL_ADDR_LEN-1:0] r_ld_paddr;
  logic                         r_ld_dtlb_hit;
  logic                         r_hold_io;

  logic w_busy;
  logic w_can_grant;
  logic w_ld_win;
  logic w_st_gnt;
  logic w_ld_gnt;
  logic w_any_gnt;

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  assign w_busy = (r_state != S_IDLE);

  // A new lookup may start when nothing is in flight, or when the current
  // response retires this cycle. rstn gates it so both rdy stay low while
  // reset is asserted.
  assign w_can_grant = rstn & ~flush & (~w_busy | rsp_rdy_i);

  // Load wins when it is alone, or when it has lost LD_STARVE_MAX times in a row.
  assign w_ld_win  = ld_req_vld_i & (~st_req_vld_i | (r_starve_cnt == c_STARVE_MAX));
  assign w_st_gnt  = w_can_grant & st_req_vld_i & ~w_ld_win;
  assign w_ld_gnt  = w_can_grant & w_ld_win;
  assign w_any_gnt = w_st_gnt | w_ld_gnt;

  // --------------------------------------------------------------------------
  // State, starvation counter, in-flight and hold registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= S_IDLE;
      r_starve_cnt  <= '0;
      r_tag         <= '0;
      r_is_st       <= 1'b0;
      r_ld_paddr    <= '0;
      r_ld_dtlb_hit <= 1'b0;
      r_hold_io     <= 1'b0;
    end else begin
      if (flush) begin
        // In-flight and buffered results are dropped; grants are already
        // blocked this cycle, so the in-flight register is left as is.
        r_state      <= S_IDLE;
        r_starve_cnt <= '0;
      end else begin
        if (w_any_gnt) begin
          r_state <= S_LOOKUP;
        end else if (w_busy && !rsp_rdy_i) begin
          r_state <= S_HOLD;
        end else begin
          r_state <= S_IDLE;
        end

        // The checker only drives its result in the lookup cycle; keep it
        // if the consumer is stalling.
        if (r_state == S_LOOKUP && !rsp_rdy_i) begin
          r_hold_io <= pma_is_io_i;
        end

        if (w_ld_gnt || !ld_req_vld_i) begin
          r_starve_cnt <= '0;
        end else if (w_st_gnt && (r_starve_cnt != c_STARVE_MAX)) begin
          r_starve_cnt <= r_starve_cnt + 1'b1;
        end
      end

      if (w_any_gnt) begin
        r_tag   <= w_st_gnt ? st_req_tag_i : ld_req_tag_i;
        r_is_st <= w_st_gnt;
      end

      // The checker samples the load address one cycle after valid, so the
      // load address/hit are held here until the next load grant.
      if (w_ld_gnt) begin
        r_ld_paddr    <= ld_req_paddr_i;
        r_ld_dtlb_hit <= ld_req_dtlb_hit_i;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign st_req_rdy_o      = w_st_gnt;
  assign ld_req_rdy_o      = w_ld_gnt;

  assign pma_st_vld_o      = w_st_gnt;
  assign pma_st_paddr_o    = w_st_gnt ? st_req_paddr_i : '0;
  assign pma_ld_vld_o      = w_ld_gnt;
  assign pma_ld_paddr_o    = r_ld_paddr;
  assign pma_ld_dtlb_hit_o = r_ld_dtlb_hit;

  assign rsp_vld_o   = w_busy & ~flush;
  assign rsp_tag_o   = r_tag;
  assign rsp_is_st_o = r_is_st;
  assign rsp_is_io_o = (r_state == S_LOOKUP) ? pma_is_io_i :
                       (r_state == S_HOLD)   ? r_hold_io   : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_lsu_pma_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lsu_pma_arb
//  Description : Directed, table-driven bench for lsu_pma_arb with a small
//                behavioural PMA checker (IO region = paddr < 0x8000_0000,
//                loads additionally require a DTLB hit).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lsu_pma_arb;

  localparam int PA = 56;
  localparam int TW = 4;

  localparam logic [PA-1:0] IO  = 56'h0000_0000_1000_0000;
  localparam logic [PA-1:0] MEM = 56'h0000_0000_8000_1000;
  localparam logic [PA-1:0] M2  = 56'h0000_0000_8000_2000;
  localparam logic [PA-1:0] Z   = '0;

  logic          clk = 1'b0;
  logic          rstn;
  logic          flush;
  logic          st_req_vld_i;
  logic [PA-1:0] st_req_paddr_i;
  logic [TW-1:0] st_req_tag_i;
  logic          st_req_rdy_o;
  logic          ld_req_vld_i;
  logic [PA-1:0] ld_req_paddr_i;
  logic          ld_req_dtlb_hit_i;
  logic [TW-1:0] ld_req_tag_i;
  logic          ld_req_rdy_o;
  logic          pma_st_vld_o;
  logic [PA-1:0] pma_st_paddr_o;
  logic          pma_ld_vld_o;
  logic [PA-1:0] pma_ld_paddr_o;
  logic          pma_ld_dtlb_hit_o;
  logic          pma_is_io_i;
  logic          rsp_vld_o;
  logic          rsp_rdy_i;
  logic [TW-1:0] rsp_tag_o;
  logic          rsp_is_st_o;
  logic          rsp_is_io_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_pma_arb #(
    .PHYSICAL_ADDR_LEN (PA),
    .TAG_W             (TW),
    .LD_STARVE_MAX     (4)
  ) dut (
    .clk               (clk),
    .rstn              (rstn),
    .flush             (flush),
    .st_req_vld_i      (st_req_vld_i),
    .st_req_paddr_i    (st_req_paddr_i),
    .st_req_tag_i      (st_req_tag_i),
    .st_req_rdy_o      (st_req_rdy_o),
    .ld_req_vld_i      (ld_req_vld_i),
    .ld_req_paddr_i    (ld_req_paddr_i),
    .ld_req_dtlb_hit_i (ld_req_dtlb_hit_i),
    .ld_req_tag_i      (ld_req_tag_i),
    .ld_req_rdy_o      (ld_req_rdy_o),
    .pma_st_vld_o      (pma_st_vld_o),
    .pma_st_paddr_o    (pma_st_paddr_o),
    .pma_ld_vld_o      (pma_ld_vld_o),
    .pma_ld_paddr_o    (pma_ld_paddr_o),
    .pma_ld_dtlb_hit_o (pma_ld_dtlb_hit_o),
    .pma_is_io_i       (pma_is_io_i),
    .rsp_vld_o         (rsp_vld_o),
    .rsp_rdy_i         (rsp_rdy_i),
    .rsp_tag_o         (rsp_tag_o),
    .rsp_is_st_o       (rsp_is_st_o),
    .rsp_is_io_o       (rsp_is_io_o)
  );

  // --------------------------------------------------------------------------
  // Behavioural PMA checker: store paddr sampled with valid, load paddr and
  // DTLB hit sampled one cycle later from the arbiter's registered outputs.
  // --------------------------------------------------------------------------
  function automatic logic in_io(input logic [PA-1:0] a);
    return a < 56'h0000_0000_8000_0000;
  endfunction

  logic          m_st_q = 1'b0;
  logic          m_ld_q = 1'b0;
  logic [PA-1:0] m_st_pa_q = '0;

  always @(posedge clk) begin
    m_st_q    <= pma_st_vld_o;
    m_ld_q    <= pma_ld_vld_o;
    m_st_pa_q <= pma_st_paddr_o;
  end

  always_comb begin
    pma_is_io_i = 1'b0;
    if (m_st_q)      pma_is_io_i = in_io(m_st_pa_q);
    else if (m_ld_q) pma_is_io_i = in_io(pma_ld_paddr_o) & pma_ld_dtlb_hit_o;
  end

  // --------------------------------------------------------------------------
  // Vector table
  // --------------------------------------------------------------------------
  typedef struct {
    logic          fl;
    logic          sv;
    logic [PA-1:0] sa;
    logic [TW-1:0] st;
    logic          lv;
    logic [PA-1:0] la;
    logic          lh;
    logic [TW-1:0] lt;
    logic          rr;
    logic          e_srdy;
    logic          e_lrdy;
    logic          e_rv;
    logic [TW-1:0] e_tag;
    logic          e_ist;
    logic          e_io;
    logic [PA-1:0] e_ldpa;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic fl, input logic sv, input logic [PA-1:0] sa, input logic [TW-1:0] st,
    input logic lv, input logic [PA-1:0] la, input logic lh, input logic [TW-1:0] lt,
    input logic rr, input logic es, input logic el, input logic ev,
    input logic [TW-1:0] et, input logic eis, input logic eio, input logic [PA-1:0] elp);
    vec_t v;
    v.fl = fl; v.sv = sv; v.sa = sa; v.st = st;
    v.lv = lv; v.la = la; v.lh = lh; v.lt = lt; v.rr = rr;
    v.e_srdy = es; v.e_lrdy = el; v.e_rv = ev;
    v.e_tag = et; v.e_ist = eis; v.e_io = eio; v.e_ldpa = elp;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    flush             = v.fl;
    st_req_vld_i      = v.sv;
    st_req_paddr_i    = v.sa;
    st_req_tag_i      = v.st;
    ld_req_vld_i      = v.lv;
    ld_req_paddr_i    = v.la;
    ld_req_dtlb_hit_i = v.lh;
    ld_req_tag_i      = v.lt;
    rsp_rdy_i         = v.rr;
  endtask

  // Drive at the falling edge, compare 2ns later (well before the next rise).
  task automatic run_vec(input vec_t v, input string nm);
    @(negedge clk);
    drive(v);
    #2;
    chk({nm, ".st_rdy"},  64'(st_req_rdy_o), 64'(v.e_srdy));
    chk({nm, ".ld_rdy"},  64'(ld_req_rdy_o), 64'(v.e_lrdy));
    chk({nm, ".pma_stv"}, 64'(pma_st_vld_o), 64'(v.e_srdy));
    chk({nm, ".pma_ldv"}, 64'(pma_ld_vld_o), 64'(v.e_lrdy));
    chk({nm, ".rsp_vld"}, 64'(rsp_vld_o),    64'(v.e_rv));
    chk({nm, ".ld_pa"},   64'(pma_ld_paddr_o), 64'(v.e_ldpa));
    if (v.e_rv) begin
      chk({nm, ".tag"},   64'(rsp_tag_o),   64'(v.e_tag));
      chk({nm, ".is_st"}, 64'(rsp_is_st_o), 64'(v.e_ist));
      chk({nm, ".is_io"}, 64'(rsp_is_io_o), 64'(v.e_io));
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, ".st_rdy"},  64'(st_req_rdy_o),      64'd0);
    chk({nm, ".ld_rdy"},  64'(ld_req_rdy_o),      64'd0);
    chk({nm, ".pma_stv"}, 64'(pma_st_vld_o),      64'd0);
    chk({nm, ".pma_stp"}, 64'(pma_st_paddr_o),    64'd0);
    chk({nm, ".pma_ldv"}, 64'(pma_ld_vld_o),      64'd0);
    chk({nm, ".pma_ldp"}, 64'(pma_ld_paddr_o),    64'd0);
    chk({nm, ".pma_ldh"}, 64'(pma_ld_dtlb_hit_o), 64'd0);
    chk({nm, ".rsp_vld"}, 64'(rsp_vld_o),         64'd0);
    chk({nm, ".tag"},     64'(rsp_tag_o),         64'd0);
    chk({nm, ".is_st"},   64'(rsp_is_st_o),       64'd0);
    chk({nm, ".is_io"},   64'(rsp_is_io_o),       64'd0);
  endtask

  initial begin
    //                 fl sv sa   st    lv la   lh lt     rr  es el ev tag   st io ldpa
    // Lone store to IO, then its response
    vecs.push_back(mk(0, 1, IO,  4'd3, 0, Z,   0, 4'd0,  1,  1, 0, 0, 4'd0, 0, 0, Z));
    vecs.push_back(mk(0, 0, Z,   4'd0, 0, Z,   0, 4'd0,  1,  0, 0, 1, 4'd3, 1, 1, Z));
    vecs.push_back(mk(0, 0, Z,   4'd0, 0, Z,   0, 4'd0,  1,  0, 0, 0, 4'd0, 0, 0, Z));
    // Load to IO with DTLB miss, load to IO with hit, load to memory
    vecs.push_back(mk(0, 0, Z,   4'd0, 1, IO,  0, 4'd5,  1,  0, 1, 0, 4'd0, 0, 0, Z));
    vecs.push_back(mk(0, 0, Z,   4'd0, 0, Z,   0, 4'd0,  1,  0, 0, 1, 4'd5, 0, 0, IO));
    vecs.push_back(mk(0, 0, Z,   4'd0, 1, IO,  1, 4'd6,  1,  0, 1, 0, 4'd0, 0, 0, IO));
    vecs.push_back(mk(0, 0, Z,   4'd0, 1, MEM, 1, 4'd7,  1,  0, 1, 1, 4'd6, 0, 1, IO));
    // Both requesting every cycle: S,S,S,S,L repeating, no bubbles
    vecs.push_back(mk(0, 1, IO,  4'd1, 1, M2,  1, 4'd9,  1,  1, 0, 1, 4'd7, 0, 0, MEM));
    vecs.push_back(mk(0, 1, IO,  4'd1, 1, M2,  1, 4'd9,  1,  1, 0, 1, 4'd1, 1, 1, MEM));
    vecs.push_back(mk(0, 1, IO,  4'd1, 1, M2,  1, 4'd9,  1,  1, 0, 1, 4'd1, 1, 1, MEM));
    vecs.push_back(mk(0, 1, IO,  4'd1, 1, M2,  1, 4'd9,  1,  1, 0, 1, 4'd1, 1, 1, MEM));
    vecs.push_back(mk(0, 1, IO,  4'd1, 1, M2,  1, 4'd9,  1,  0, 1, 1, 4'd1, 1, 1, MEM));
    vecs.push_back(mk(0, 1, IO,  4'd1, 1, M2,  1, 4'd9,  1,  1, 0, 1, 4'd9, 0, 0, M2));
    vecs.push_back(mk(0, 1, IO,  4'd1, 1, M2,  1, 4'd9,  1,  1, 0, 1, 4'd1, 1, 1, M2));
    vecs.push_back(mk(0, 1, IO,  4'd1, 1, M2,  1, 4'd9,  1,  1, 0, 1, 4'd1, 1, 1, M2));
    vecs.push_back(mk(0, 1, IO,  4'd1, 1, M2,  1, 4'd9,  1,  1, 0, 1, 4'd1, 1, 1, M2));
    vecs.push_back(mk(0, 1, IO,  4'd1, 1, M2,  1, 4'd9,  1,  0, 1, 1, 4'd1, 1, 1, M2));
    // Load granted, consumer stalls 3 cycles, store waits then wins on retire
    vecs.push_back(mk(0, 0, Z,   4'd0, 1, IO,  1, 4'd10, 1,  0, 1, 1, 4'd9, 0, 0, M2));
    vecs.push_back(mk(0, 1, MEM, 4'd2, 0, Z,   0, 4'd0,  0,  0, 0, 1, 4'd10,0, 1, IO));
    vecs.push_back(mk(0, 1, MEM, 4'd2, 0, Z,   0, 4'd0,  0,  0, 0, 1, 4'd10,0, 1, IO));
    vecs.push_back(mk(0, 1, MEM, 4'd2, 0, Z,   0, 4'd0,  0,  0, 0, 1, 4'd10,0, 1, IO));
    vecs.push_back(mk(0, 1, MEM, 4'd2, 0, Z,   0, 4'd0,  1,  1, 0, 1, 4'd10,0, 1, IO));
    vecs.push_back(mk(0, 0, Z,   4'd0, 0, Z,   0, 4'd0,  1,  0, 0, 1, 4'd2, 1, 0, IO));
    // Starve counter built to 3, flush in LOOKUP clears it: 4 stores again
    vecs.push_back(mk(0, 1, IO,  4'd4, 1, IO,  1, 4'd11, 1,  1, 0, 0, 4'd0, 0, 0, IO));
    vecs.push_back(mk(0, 1, IO,  4'd4, 1, IO,  1, 4'd11, 1,  1, 0, 1, 4'd4, 1, 1, IO));
    vecs.push_back(mk(0, 1, IO,  4'd4, 1, IO,  1, 4'd11, 1,  1, 0, 1, 4'd4, 1, 1, IO));
    vecs.push_back(mk(1, 1, IO,  4'd4, 1, IO,  1, 4'd11, 1,  0, 0, 0, 4'd0, 0, 0, IO));
    vecs.push_back(mk(0, 1, IO,  4'd4, 1, IO,  1, 4'd11, 1,  1, 0, 0, 4'd0, 0, 0, IO));
    vecs.push_back(mk(0, 1, IO,  4'd4, 1, IO,  1, 4'd11, 1,  1, 0, 1, 4'd4, 1, 1, IO));
    vecs.push_back(mk(0, 1, IO,  4'd4, 1, IO,  1, 4'd11, 1,  1, 0, 1, 4'd4, 1, 1, IO));
    vecs.push_back(mk(0, 1, IO,  4'd4, 1, IO,  1, 4'd11, 1,  1, 0, 1, 4'd4, 1, 1, IO));
    vecs.push_back(mk(0, 1, IO,  4'd4, 1, IO,  1, 4'd11, 1,  0, 1, 1, 4'd4, 1, 1, IO));
    // Load response stalls into HOLD, then flushed
    vecs.push_back(mk(0, 0, Z,   4'd0, 0, Z,   0, 4'd0,  0,  0, 0, 1, 4'd11,0, 1, IO));
    vecs.push_back(mk(1, 1, IO,  4'd12,0, Z,   0, 4'd0,  0,  0, 0, 0, 4'd0, 0, 0, IO));
    vecs.push_back(mk(0, 1, IO,  4'd12,0, Z,   0, 4'd0,  0,  1, 0, 0, 4'd0, 0, 0, IO));
    vecs.push_back(mk(0, 0, Z,   4'd0, 0, Z,   0, 4'd0,  1,  0, 0, 1, 4'd12,1, 1, IO));
    vecs.push_back(mk(0, 0, Z,   4'd0, 0, Z,   0, 4'd0,  1,  0, 0, 0, 4'd0, 0, 0, IO));

    // Reset with both requesters active: everything must read 0
    rstn = 1'b0;
    drive(mk(0, 1, IO, 4'd3, 1, IO, 1, 4'd5, 1, 0, 0, 0, 4'd0, 0, 0, Z));
    #3;
    chk_all_zero("reset");
    @(negedge clk);
    drive(mk(0, 0, Z, 4'd0, 0, Z, 0, 4'd0, 1, 0, 0, 0, 4'd0, 0, 0, Z));
    rstn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i], $sformatf("v%0d", i));
    end

    // Async reset in the middle of HOLD, then the lone-store case again
    run_vec(mk(0, 1, IO, 4'd3, 0, Z, 0, 4'd0, 1, 1, 0, 0, 4'd0, 0, 0, IO), "r0");
    run_vec(mk(0, 0, Z,  4'd0, 0, Z, 0, 4'd0, 0, 0, 0, 1, 4'd3, 1, 1, IO), "r1");
    run_vec(mk(0, 1, IO, 4'd6, 1, IO, 1, 4'd7, 0, 0, 0, 1, 4'd3, 1, 1, IO), "r2_hold");
    #1;
    rstn = 1'b0;
    #1;
    chk_all_zero("rst_hold");
    @(negedge clk);
    drive(mk(0, 0, Z, 4'd0, 0, Z, 0, 4'd0, 1, 0, 0, 0, 4'd0, 0, 0, Z));
    rstn = 1'b1;
    run_vec(mk(0, 1, IO, 4'd3, 0, Z, 0, 4'd0, 1, 1, 0, 0, 4'd0, 0, 0, Z), "p0");
    run_vec(mk(0, 0, Z,  4'd0, 0, Z, 0, 4'd0, 1, 0, 0, 1, 4'd3, 1, 1, Z), "p1");
    run_vec(mk(0, 0, Z,  4'd0, 0, Z, 0, 4'd0, 1, 0, 0, 0, 4'd0, 0, 0, Z), "p2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
